ides8_soft_rx: RTL and testbench

//  Fabric-logic 8:1 deserializer; receive-side counterpart of the OSER8 serializer path.

---
 rtl/ides_pkg.sv | 12 +
 rtl/ides_align_fsm.sv | 98 +++++++++
 rtl/ides8_soft_rx.sv | 78 +++++++
 tb/tb_ides8_soft_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ides_pkg.sv
// Shared types and defaults for the soft 8:1 deserializer.
package ides_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } ides_state_t;

  localparam logic [7:0] DEFAULT_TRAIN = 8'hAA;

endpackage

// File: rtl/ides_align_fsm.sv
// Word-alignment tracker: decides slips, lock and lock loss from per-word pattern matches.
module ides_align_fsm
  import ides_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic fclk_w,
  input  logic rst,
  input  logic word_done,
  input  logic align_en,
  input  logic match,
  output logic slip_req,
  output logic locked,
  output logic err_inc
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

  ides_state_t   state, state_next;
  logic [MW-1:0] match_cnt, match_next;
  logic [LW-1:0] miss_cnt, miss_next;

  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
    end
  end

  // Only completed training words move the FSM; payload words leave it frozen.
  always_comb begin
    state_next = state;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    slip_req   = 1'b0;
    err_inc    = 1'b0;
    if (word_done && align_en) begin
      case (state)
        HUNT: begin
          if (match) begin
            if (LOCK_COUNT <= 1) begin
              state_next = LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              state_next = CHECK;
              match_next = MW'(1);
            end
          end else begin
            slip_req = 1'b1;
          end
        end
        CHECK: begin
          if (match) begin
            if (match_cnt == LOCK_LAST) begin
              state_next = LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_cnt + MW'(1);
            end
          end else begin
            state_next = HUNT;
            match_next = '0;
            slip_req   = 1'b1;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_next = '0;
          end else begin
            err_inc = 1'b1;
            // Losing lock does not slip: the old boundary is the best first guess.
            if (miss_cnt == LOSS_LAST) begin
              state_next = HUNT;
              miss_next  = '0;
            end else begin
              miss_next = miss_cnt + LW'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/ides8_soft_rx.sv
// Fabric 8:1 deserializer: LSB-first word assembly, bitslip alignment, lock flag and word clock.
module ides8_soft_rx
  import ides_pkg::*;
#(
  parameter int              WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEFAULT_TRAIN),
  parameter int              LOCK_COUNT    = 4,
  parameter int              LOSS_COUNT    = 2
) (
  input  logic             fclk_w,
  input  logic             rst,
  input  logic             din,
  input  logic             align_en,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             locked_o,
  output logic             bitslip_o,
  output logic [7:0]       err_cnt_o,
  output logic             pclk_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

  // Bit 0 of the shift register would fall out on the completing edge, so it is never stored.
  logic [WIDTH-1:1] shreg;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt, cnt_next;
  logic             slip_hold, word_done, match, slip_req, err_inc;

  assign word      = {din, shreg};
  assign word_done = !slip_hold && (cnt == LAST);
  assign match     = (word == TRAIN_PATTERN);

  always_comb begin
    cnt_next = cnt;
    if (!slip_hold) cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // A slip holds cnt at 0 for one edge and drops that bit, moving the boundary one bit later.
  always_ff @(posedge fclk_w) begin
    if (!rst) begin
      cnt       <= '0;
      shreg     <= '0;
      q_o       <= '0;
      q_valid_o <= 1'b0;
      bitslip_o <= 1'b0;
      slip_hold <= 1'b0;
      err_cnt_o <= 8'd0;
      pclk_o    <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      pclk_o    <= (cnt_next < HALF);
      q_valid_o <= word_done;
      bitslip_o <= slip_hold;
      slip_hold <= slip_req;
      if (!slip_hold) shreg <= word[WIDTH-1:1];
      if (word_done) q_o <= word;
      if (err_inc && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  ides_align_fsm #(
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_COUNT(LOSS_COUNT)
  ) u_fsm (
    .fclk_w   (fclk_w),
    .rst      (rst),
    .word_done(word_done),
    .align_en (align_en),
    .match    (match),
    .slip_req (slip_req),
    .locked   (locked_o),
    .err_inc  (err_inc)
  );

endmodule

// File: tb/tb_ides8_soft_rx.sv
// Directed bench for ides8_soft_rx: three instances (default, 8'h1E pattern, long loss count) on one stream.
module tb_ides8_soft_rx;

  logic fclk_w = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic align_en = 1'b0;

  logic [7:0] a_q, b_q, c_q, a_err, b_err, c_err;
  logic a_valid, a_locked, a_slip, a_pclk;
  logic b_valid, b_locked, b_slip, b_pclk;
  logic c_valid, c_locked, c_slip, c_pclk;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 fclk_w = ~fclk_w;

  ides8_soft_rx dut_a (
    .fclk_w(fclk_w), .rst(rst), .din(din), .align_en(align_en),
    .q_o(a_q), .q_valid_o(a_valid), .locked_o(a_locked), .bitslip_o(a_slip),
    .err_cnt_o(a_err), .pclk_o(a_pclk)
  );

  ides8_soft_rx #(.TRAIN_PATTERN(8'h1E)) dut_b (
    .fclk_w(fclk_w), .rst(rst), .din(din), .align_en(align_en),
    .q_o(b_q), .q_valid_o(b_valid), .locked_o(b_locked), .bitslip_o(b_slip),
    .err_cnt_o(b_err), .pclk_o(b_pclk)
  );

  ides8_soft_rx #(.LOSS_COUNT(1000)) dut_c (
    .fclk_w(fclk_w), .rst(rst), .din(din), .align_en(align_en),
    .q_o(c_q), .q_valid_o(c_valid), .locked_o(c_locked), .bitslip_o(c_slip),
    .err_cnt_o(c_err), .pclk_o(c_pclk)
  );

  task automatic drive_bit(input logic b);
    din = b;
    @(posedge fclk_w);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) drive_bit(i[0]);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive_bit(i[0]);
    n_compared++; if (a_q !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_q got %h want 00", a_q); end
    n_compared++; if (a_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid got %b want 0", a_valid); end
    n_compared++; if (a_locked !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_locked got %b want 0", a_locked); end
    n_compared++; if (a_err !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_err got %h want 00", a_err); end
    n_compared++; if (a_pclk !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_pclk got %b want 0", a_pclk); end
    n_compared++; if (a_slip !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_slip got %b want 0", a_slip); end
    rst = 1'b1;
  endtask

  task automatic test_aligned();
    logic [7:0] pat;
    pat = 8'hAA;
    align_en = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) begin
        drive_bit(pat[i]);
        n_compared++; if (a_slip !== 1'b0) begin n_mismatched++; $display("[TB] FAIL aligned_slip w%0d b%0d got %b want 0", w, i, a_slip); end
        n_compared++; if (a_valid !== (i == 7)) begin n_mismatched++; $display("[TB] FAIL aligned_valid w%0d b%0d got %b want %b", w, i, a_valid, (i == 7)); end
        n_compared++; if (a_pclk !== (i == 7 || i < 3)) begin n_mismatched++; $display("[TB] FAIL aligned_pclk w%0d b%0d got %b want %b", w, i, a_pclk, (i == 7 || i < 3)); end
      end
      n_compared++; if (a_q !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL aligned_q w%0d got %h want aa", w, a_q); end
      n_compared++; if (a_locked !== (w == 3)) begin n_mismatched++; $display("[TB] FAIL aligned_locked w%0d got %b want %b", w, a_locked, (w == 3)); end
    end
  endtask

  task automatic test_loss();
    logic [7:0] words [8];
    logic [7:0] exp_err [8];
    logic       exp_lock [8];
    logic [7:0] w;
    words    = '{8'h00, 8'hAA, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    exp_err  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    exp_lock = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      w = words[k];
      for (int i = 0; i < 8; i++) begin
        drive_bit(w[i]);
        n_compared++; if (a_slip !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss_slip w%0d b%0d got %b want 0", k, i, a_slip); end
      end
      n_compared++; if (a_q !== w) begin n_mismatched++; $display("[TB] FAIL loss_q w%0d got %h want %h", k, a_q, w); end
      n_compared++; if (a_err !== exp_err[k]) begin n_mismatched++; $display("[TB] FAIL loss_err w%0d got %0d want %0d", k, a_err, exp_err[k]); end
      n_compared++; if (a_locked !== exp_lock[k]) begin n_mismatched++; $display("[TB] FAIL loss_locked w%0d got %b want %b", k, a_locked, exp_lock[k]); end
    end
  endtask

  task automatic test_payload();
    logic [7:0] w;
    align_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      w = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        drive_bit(w[i]);
        n_compared++; if (a_valid !== (i == 7)) begin n_mismatched++; $display("[TB] FAIL payload_valid w%0d b%0d got %b want %b", k, i, a_valid, (i == 7)); end
        n_compared++; if (a_slip !== 1'b0) begin n_mismatched++; $display("[TB] FAIL payload_slip w%0d b%0d got %b want 0", k, i, a_slip); end
      end
      n_compared++; if (a_q !== w) begin n_mismatched++; $display("[TB] FAIL payload_q w%0d got %h want %h", k, a_q, w); end
      n_compared++; if (a_err !== 8'd3) begin n_mismatched++; $display("[TB] FAIL payload_err w%0d got %0d want 3", k, a_err); end
      n_compared++; if (a_locked !== 1'b1) begin n_mismatched++; $display("[TB] FAIL payload_locked w%0d got %b want 1", k, a_locked); end
    end
    align_en = 1'b1;
  endtask

  // Stream lags the word boundary by 3 bits: the pattern starts at t=3, slips land at t=8,17,26.
  task automatic test_misaligned();
    logic [7:0] pat;
    int         vt [8];
    logic [7:0] vw [8];
    int         k;
    int         slips;
    logic       exp_v, exp_s;
    pat = 8'h1E;
    vt = '{7, 16, 25, 34, 42, 50, 58, 66};
    vw = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h1E, 8'h1E, 8'h1E, 8'h1E};
    k = 0;
    slips = 0;
    do_reset(2);
    align_en = 1'b1;
    for (int t = 0; t <= 66; t++) begin
      drive_bit(pat[(t + 5) % 8]);
      exp_v = (k < 8) && (t == vt[k]);
      exp_s = (t == 8) || (t == 17) || (t == 26);
      if (b_slip === 1'b1) slips++;
      n_compared++; if (b_slip !== exp_s) begin n_mismatched++; $display("[TB] FAIL misalign_slip t%0d got %b want %b", t, b_slip, exp_s); end
      n_compared++; if (b_valid !== exp_v) begin n_mismatched++; $display("[TB] FAIL misalign_valid t%0d got %b want %b", t, b_valid, exp_v); end
      if (exp_v) begin
        n_compared++; if (b_q !== vw[k]) begin n_mismatched++; $display("[TB] FAIL misalign_q t%0d got %h want %h", t, b_q, vw[k]); end
        n_compared++; if (b_locked !== (t >= 58)) begin n_mismatched++; $display("[TB] FAIL misalign_locked t%0d got %b want %b", t, b_locked, (t >= 58)); end
        k++;
      end
      if (t == 8 || t == 11 || t == 12) begin
        n_compared++; if (b_pclk !== (t != 12)) begin n_mismatched++; $display("[TB] FAIL misalign_pclk t%0d got %b want %b", t, b_pclk, (t != 12)); end
      end
    end
    n_compared++; if (slips != 3) begin n_mismatched++; $display("[TB] FAIL misalign_slip_count got %0d want 3", slips); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] pat;
    pat = 8'hAA;
    do_reset(1);
    align_en = 1'b1;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) drive_bit(pat[i]);
    for (int i = 0; i < 5; i++) drive_bit(pat[i]);
    rst = 1'b0;
    drive_bit(1'b1);
    rst = 1'b1;
    n_compared++; if (a_q !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midrst_q got %h want 00", a_q); end
    n_compared++; if (a_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_valid got %b want 0", a_valid); end
    n_compared++; if (a_locked !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_locked got %b want 0", a_locked); end
    n_compared++; if (a_slip !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_slip got %b want 0", a_slip); end
    n_compared++; if (a_err !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midrst_err got %h want 00", a_err); end
    n_compared++; if (a_pclk !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_pclk got %b want 0", a_pclk); end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) drive_bit(pat[i]);
      n_compared++; if (a_q !== 8'hAA) begin n_mismatched++; $display("[TB] FAIL midrst_relock_q w%0d got %h want aa", k, a_q); end
      n_compared++; if (a_locked !== (k == 3)) begin n_mismatched++; $display("[TB] FAIL midrst_relock_locked w%0d got %b want %b", k, a_locked, (k == 3)); end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] pat;
    pat = 8'hAA;
    do_reset(1);
    align_en = 1'b1;
    for (int k = 0; k < 4; k++) for (int i = 0; i < 8; i++) drive_bit(pat[i]);
    n_compared++; if (c_locked !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_lock got %b want 1", c_locked); end
    for (int n = 1; n <= 300; n++) begin
      for (int i = 0; i < 8; i++) drive_bit(1'b0);
      if (n == 254) begin
        n_compared++; if (c_err !== 8'd254) begin n_mismatched++; $display("[TB] FAIL sat_err254 got %0d want 254", c_err); end
      end
      if (n == 255 || n == 300) begin
        n_compared++; if (c_err !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_err%0d got %0d want 255", n, c_err); end
      end
    end
    n_compared++; if (c_locked !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_locked got %b want 1", c_locked); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_aligned();
    test_loss();
    test_payload();
    test_misaligned();
    test_mid_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
